// File: rtl/cube_pixel_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cube_pixel_out                                         |
// | Description : Final pixel stage of the raymarched cube pipeline.     |
// |               Dithers cube luma to 2-bit RGB, draws a scrolling      |
// |               checkerboard behind the cube, and produces VGA sync    |
// |               and display enable, all aligned after two registers.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cube_pixel_out #(
   parameter int   H_VISIBLE    = 640,
   parameter int   V_VISIBLE    = 480,
   parameter int   H_TOTAL      = 800,
   parameter int   V_TOTAL      = 525,
   parameter int   H_SYNC_START = 656,
   parameter int   H_SYNC_END   = 752,
   parameter int   V_SYNC_START = 490,
   parameter int   V_SYNC_END   = 492,
   parameter logic SYNC_ACTIVE  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] h_count,
   input  logic [9:0]  v_count,
   input  logic        frame,
   input  logic        cube_visible,
   input  logic [5:0]  cube_luma,
   output logic [1:0]  red,
   output logic [1:0]  green,
   output logic [1:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        de
);

   localparam logic [10:0] c_h_visible    = 11'(H_VISIBLE);
   localparam logic [9:0]  c_v_visible    = 10'(V_VISIBLE);
   localparam logic [10:0] c_h_last       = 11'(H_TOTAL - 1);
   localparam logic [9:0]  c_v_last       = 10'(V_TOTAL - 1);
   localparam logic [10:0] c_h_sync_start = 11'(H_SYNC_START);
   localparam logic [10:0] c_h_sync_end   = 11'(H_SYNC_END);
   localparam logic [9:0]  c_v_sync_start = 10'(V_SYNC_START);
   localparam logic [9:0]  c_v_sync_end   = 10'(V_SYNC_END);

   // Scroll offset for the checkerboard, advanced once per frame
   logic [7:0] r_scroll;

   // Stage 1 registers
   logic       r_s1_active;
   logic       r_s1_hs;
   logic       r_s1_vs;
   logic [3:0] r_s1_thresh;
   logic       r_s1_checker;
   logic       r_s1_visible;
   logic [5:0] r_s1_luma;

   // Combinational stage-1 terms
   logic       w_active;
   logic       w_hs;
   logic       w_vs;
   logic [3:0] w_bayer;
   logic [3:0] w_thresh;
   logic [7:0] w_chk_sum;
   logic       w_checker;
   logic       w_frame_end;

   // Combinational stage-2 terms
   logic [1:0] w_lvl;
   logic [3:0] w_frac;
   logic [1:0] w_q;

   // Counter-derived region, sync windows and frame-end strobe
   always_comb begin
      w_active    = (h_count < c_h_visible) && (v_count < c_v_visible);
      w_hs        = (h_count >= c_h_sync_start) && (h_count < c_h_sync_end);
      w_vs        = (v_count >= c_v_sync_start) && (v_count < c_v_sync_end);
      w_frame_end = (h_count == c_h_last) && (v_count == c_v_last);
      w_chk_sum   = h_count[7:0] + r_scroll;
      w_checker   = w_chk_sum[5] ^ v_count[5];
   end

   // 4x4 Bayer threshold; odd frames use the complement so the pattern
   // flips every frame and temporal averaging hides the dither
   always_comb begin
      w_bayer = 4'd0;
      case ({v_count[1:0], h_count[1:0]})
         4'd0:  w_bayer = 4'd0;
         4'd1:  w_bayer = 4'd8;
         4'd2:  w_bayer = 4'd2;
         4'd3:  w_bayer = 4'd10;
         4'd4:  w_bayer = 4'd12;
         4'd5:  w_bayer = 4'd4;
         4'd6:  w_bayer = 4'd14;
         4'd7:  w_bayer = 4'd6;
         4'd8:  w_bayer = 4'd3;
         4'd9:  w_bayer = 4'd11;
         4'd10: w_bayer = 4'd1;
         4'd11: w_bayer = 4'd9;
         4'd12: w_bayer = 4'd15;
         4'd13: w_bayer = 4'd7;
         4'd14: w_bayer = 4'd13;
         4'd15: w_bayer = 4'd5;
      endcase
      // 15 - t is a bitwise inversion for a 4-bit value
      w_thresh = frame ? ~w_bayer : w_bayer;
   end

   // Scroll counter; reset wins over a coincident frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scroll <= 8'd0;
      end else if (w_frame_end) begin
         r_scroll <= r_scroll + 8'd1;
      end
   end

   // Stage 1 pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_active  <= 1'b0;
         r_s1_hs      <= 1'b0;
         r_s1_vs      <= 1'b0;
         r_s1_thresh  <= 4'd0;
         r_s1_checker <= 1'b0;
         r_s1_visible <= 1'b0;
         r_s1_luma    <= 6'd0;
      end else begin
         r_s1_active  <= w_active;
         r_s1_hs      <= w_hs;
         r_s1_vs      <= w_vs;
         r_s1_thresh  <= w_thresh;
         r_s1_checker <= w_checker;
         r_s1_visible <= cube_visible;
         r_s1_luma    <= cube_luma;
      end
   end

   // Ordered-dither quantisation of luma to 2 bits, saturating at 3
   always_comb begin
      w_lvl  = r_s1_luma[5:4];
      w_frac = r_s1_luma[3:0];
      w_q    = w_lvl;
      if ((w_frac > r_s1_thresh) && (w_lvl != 2'd3)) begin
         w_q = w_lvl + 2'd1;
      end
   end

   // Stage 2 output register: colour select, sync polarity, enable
   always_ff @(posedge clk) begin
      if (rst) begin
         red   <= 2'd0;
         green <= 2'd0;
         blue  <= 2'd0;
         hsync <= ~SYNC_ACTIVE;
         vsync <= ~SYNC_ACTIVE;
         de    <= 1'b0;
      end else begin
         if (!r_s1_active) begin
            red   <= 2'd0;
            green <= 2'd0;
            blue  <= 2'd0;
         end else if (r_s1_visible) begin
            red   <= w_q;
            green <= w_q;
            blue  <= w_q;
         end else begin
            red   <= 2'd0;
            green <= 2'd0;
            blue  <= {1'b0, r_s1_checker};
         end
         hsync <= r_s1_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync <= r_s1_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         de    <= r_s1_active;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cube_pixel_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cube_pixel_out                                      |
// | Description : Directed self-checking bench for cube_pixel_out.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cube_pixel_out;

   logic        clk;
   logic        rst;
   logic [10:0] h_count;
   logic [9:0]  v_count;
   logic        frame;
   logic        cube_visible;
   logic [5:0]  cube_luma;
   logic [1:0]  red;
   logic [1:0]  green;
   logic [1:0]  blue;
   logic        hsync;
   logic        vsync;
   logic        de;

   int errors = 0;
   int checks = 0;

   cube_pixel_out dut (
      .clk          (clk),
      .rst          (rst),
      .h_count      (h_count),
      .v_count      (v_count),
      .frame        (frame),
      .cube_visible (cube_visible),
      .cube_luma    (cube_luma),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .hsync        (hsync),
      .vsync        (vsync),
      .de           (de)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold one pixel's inputs through both pipeline stages, then check
   task automatic px(input string tag, input int h, input int v, input logic f,
                     input logic vis, input logic [5:0] lu, input logic [5:0] ergb,
                     input logic ede, input logic ehs, input logic evs);
      h_count      = 11'(h);
      v_count      = 10'(v);
      frame        = f;
      cube_visible = vis;
      cube_luma    = lu;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(ergb));
      chk({tag, "_de"},  32'(de),    32'(ede));
      chk({tag, "_hs"},  32'(hsync), 32'(ehs));
      chk({tag, "_vs"},  32'(vsync), 32'(evs));
   endtask

   // One-cycle frame-end strobe on the counter inputs
   task automatic frame_end();
      h_count = 11'd799;
      v_count = 10'd524;
      @(posedge clk);
      #1;
      h_count = 11'd0;
      v_count = 10'd0;
   endtask

   initial begin
      int first_de, de_off, first_hs, hs_back;
      rst          = 1'b1;
      h_count      = 11'd0;
      v_count      = 10'd0;
      frame        = 1'b0;
      cube_visible = 1'b1;
      cube_luma    = 6'h3F;
      repeat (3) @(posedge clk);
      #1;
      // Active pixel with bright cube on the inputs, yet reset holds outputs
      chk("rst_rgb", 32'({red, green, blue}), 32'd0);
      chk("rst_de",  32'(de),    32'd0);
      chk("rst_hs",  32'(hsync), 32'd1);
      chk("rst_vs",  32'(vsync), 32'd1);

      // Free-running line after reset release
      cube_visible = 1'b0;
      rst      = 1'b0;
      first_de = -1; de_off = -1; first_hs = -1; hs_back = -1;
      for (int k = 0; k < 800; k++) begin
         h_count = 11'(k);
         @(posedge clk);
         #1;
         if (de && first_de < 0) first_de = k;
         if (!de && first_de >= 0 && de_off < 0) de_off = k;
         if (!hsync && first_hs < 0) first_hs = k;
         if (hsync && first_hs >= 0 && hs_back < 0) hs_back = k;
      end
      chk("run_first_de", 32'(first_de), 32'd1);
      chk("run_de_off",   32'(de_off),   32'd641);
      chk("run_hs_low",   32'(first_hs), 32'd657);
      chk("run_hs_high",  32'(hs_back),  32'd753);

      // Dither, luma 0x28 (lvl 2, frac 8)
      px("d_h0v0",    0, 0, 1'b0, 1'b1, 6'h28, 6'b111111, 1'b1, 1'b1, 1'b1);
      px("d_h1v0",    1, 0, 1'b0, 1'b1, 6'h28, 6'b101010, 1'b1, 1'b1, 1'b1);
      px("d_h1v0_f1", 1, 0, 1'b1, 1'b1, 6'h28, 6'b111111, 1'b1, 1'b1, 1'b1);
      px("d_h3v3",    3, 3, 1'b0, 1'b1, 6'h28, 6'b111111, 1'b1, 1'b1, 1'b1);
      px("d_h0v3",    0, 3, 1'b0, 1'b1, 6'h28, 6'b101010, 1'b1, 1'b1, 1'b1);
      px("d_h0v0_f1", 0, 0, 1'b1, 1'b1, 6'h28, 6'b101010, 1'b1, 1'b1, 1'b1);
      // Saturation and floor
      px("sat_h0v3",  0, 3, 1'b0, 1'b1, 6'h3F, 6'b111111, 1'b1, 1'b1, 1'b1);
      px("sat_h1v0",  1, 0, 1'b1, 1'b1, 6'h3F, 6'b111111, 1'b1, 1'b1, 1'b1);
      px("zero_h0v0", 0, 0, 1'b0, 1'b1, 6'h00, 6'b000000, 1'b1, 1'b1, 1'b1);
      px("zero_h0v3", 0, 3, 1'b1, 1'b1, 6'h00, 6'b000000, 1'b1, 1'b1, 1'b1);
      // frac 15 against t=15 and t=14
      px("f15_t15",   0, 3, 1'b0, 1'b1, 6'h0F, 6'b000000, 1'b1, 1'b1, 1'b1);
      px("f15_t14",   2, 1, 1'b0, 1'b1, 6'h0F, 6'b010101, 1'b1, 1'b1, 1'b1);

      // Background checkerboard, scroll = 0
      px("bg_h32v0",  32, 0,  1'b0, 1'b0, 6'h3F, 6'b000001, 1'b1, 1'b1, 1'b1);
      px("bg_h0v0",   0,  0,  1'b0, 1'b0, 6'h3F, 6'b000000, 1'b1, 1'b1, 1'b1);
      px("bg_h0v32",  0,  32, 1'b0, 1'b0, 6'h3F, 6'b000001, 1'b1, 1'b1, 1'b1);

      // Scroll = 32
      repeat (32) frame_end();
      px("sc32_h0",   0,  0, 1'b0, 1'b0, 6'h00, 6'b000001, 1'b1, 1'b1, 1'b1);
      px("sc32_h32",  32, 0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1, 1'b1, 1'b1);
      // Scroll wraps back to 0 after 256 frame ends
      repeat (224) frame_end();
      px("sc0_h0",    0,  0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1, 1'b1, 1'b1);
      px("sc0_h32",   32, 0, 1'b0, 1'b0, 6'h00, 6'b000001, 1'b1, 1'b1, 1'b1);
      // Scroll = 1 makes h=31 land in the upper half of the tile
      frame_end();
      px("sc1_h31",   31, 0, 1'b0, 1'b0, 6'h00, 6'b000001, 1'b1, 1'b1, 1'b1);
      // Reset on the frame-end cycle must leave scroll at 0
      rst     = 1'b1;
      h_count = 11'd799;
      v_count = 10'd524;
      @(posedge clk);
      #1;
      rst = 1'b0;
      px("rstpri_h31", 31, 0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1, 1'b1, 1'b1);

      // Blanking and sync windows
      px("blk_h700",  700, 100, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b0, 1'b1);
      px("blk_v500",  100, 500, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b1, 1'b1);
      px("blk_h900",  900, 0,   1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b1, 1'b1);
      px("blk_v600",  0,   600, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b1, 1'b1);
      px("sy_655_489", 655, 489, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b1, 1'b1);
      px("sy_656_490", 656, 490, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b0, 1'b0);
      px("sy_751_491", 751, 491, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b0, 1'b0);
      px("sy_752_492", 752, 492, 1'b0, 1'b1, 6'h3F, 6'b000000, 1'b0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cube_pixel_out.md
Name: cube_pixel_out

Overview:
- Final output stage of the raymarched cube pipeline. It consumes the cube core's held `cube_visible` and `cube_luma` (6-bit) result and the VGA timing counters.
- Produces registered 2-bit-per-channel RGB, hsync, vsync and display-enable, all aligned to one another.
- Luma is quantised to 2 bits with a 4x4 ordered dither that alternates with the frame bit.
- Non-cube pixels show a scrolling checkerboard background.

Parameters:
- H_VISIBLE, 640, active pixels per line
- V_VISIBLE, 480, active lines per frame
- H_TOTAL, 800, pixels per line including blanking
- V_TOTAL, 525, lines per frame including blanking
- H_SYNC_START, 656, first h_count with hsync asserted
- H_SYNC_END, 752, first h_count after hsync
- V_SYNC_START, 490, first v_count with vsync asserted
- V_SYNC_END, 492, first v_count after vsync
- SYNC_ACTIVE, 0, asserted sync level (0 = active-low)

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- h_count  input  11  horizontal pixel counter, 0..H_TOTAL-1
- v_count  input  10  vertical line counter, 0..V_TOTAL-1
- frame  input  1  frame parity bit
- cube_visible  input  1  cube hit flag from cube core (held between updates)
- cube_luma  input  6  cube brightness from cube core
- red  output  2  red channel
- green  output  2  green channel
- blue  output  2  blue channel
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  display enable (active region)

Behaviour:
- One clock domain; `rst` is synchronous and active-high. It is sampled only on the rising edge of `clk`.
- Reset values:
  - red, green, blue = 0; de = 0.
  - hsync and vsync = ~SYNC_ACTIVE (deasserted).
  - scroll counter = 0; all pipeline registers = 0 with sync bits deasserted.
- Reset mid-frame clears the pipeline immediately. Outputs resume a valid pattern 2 cycles after `rst` falls.
- Latency: 2-stage pipeline. Outputs at cycle N+2 reflect h_count, v_count, frame, cube_visible and cube_luma sampled at cycle N.
- Stage 1 (registered):
  - active = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
  - hs = (H_SYNC_START <= h_count < H_SYNC_END); vs = (V_SYNC_START <= v_count < V_SYNC_END).
  - Bayer threshold t is taken from the matrix below, indexed by row = v_count[1:0], column = h_count[1:0]. When frame=1, t = 15 - t.
    - row0: 0 8 2 10
    - row1: 12 4 14 6
    - row2: 3 11 1 9
    - row3: 15 7 13 5
  - checker bit = (h_count[7:0] + scroll)[5] XOR v_count[5], with 8-bit wrapping add.
  - cube_visible and cube_luma are registered unchanged.
- Stage 2 (registered outputs):
  - Dither: lvl = luma[5:4], frac = luma[3:0]. q = lvl + 1 if (frac > t and lvl < 3), else q = lvl. Saturates at 3.
  - If !active: RGB = 0.
  - Else if visible: red = green = blue = q.
  - Else (background): checker=1 gives red=0, green=0, blue=1; checker=0 gives all 0.
  - hsync = hs ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync likewise from vs; de = active.
- Scroll counter (8-bit):
  - Increments by 1 on the cycle where h_count == H_TOTAL-1 and v_count == V_TOTAL-1.
  - Wraps 255 -> 0.
  - Reset takes priority over increment in the same cycle.
- Sync and blanking are computed from the counters alone and do not depend on cube inputs.
- Out-of-range counters (h_count >= H_TOTAL, v_count >= V_TOTAL) are treated as blanking: de = 0, RGB = 0. Sync still follows the range compares.

Test Plan:
- Reset, then free-running counters. While rst=1, outputs are 0 and sync is high. After release, first de=1 appears 2 cycles after the (h=0, v=0) input, and hsync goes low exactly 2 cycles after h_count=656.
- cube_visible=1, luma=6'h28 (lvl=2, frac=8), frame=0. At positions with t<8, RGB=3,3,3; with t>=8, RGB=2,2,2. At h[1:0]=1, v[1:0]=0 (t=8) the output is 2; with frame=1 (t=7) the same pixel is 3.
- Saturation: luma=6'h3F gives RGB=3 at every position. luma=6'h00 gives RGB=0 at every position.
- Background: cube_visible=0, scroll=0. Pixel h=32, v=0 gives blue=1, red=green=0. Pixel h=0, v=0 gives RGB=0. After 32 frame-end events, pixel h=0, v=0 gives blue=1.
- Scroll wrap and reset priority: 256 frame ends return scroll to 0. Asserting rst on the frame-end cycle leaves scroll=0.
- Blanking: cube_visible=1, luma=6'h3F at h=700, v=100 and at h=100, v=500 gives RGB=0 and de=0. vsync is low only for v_count 490..491 (output delayed 2 cycles).
